// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit sitting directly after the EX-stage ALU.
//
// Takes the ALU result either as an effective address (loads/stores) or as a
// plain writeback value. Drives a single-outstanding req/ready data-memory port
// with byte/half/word alignment, write strobes and load sign/zero extension,
// and produces exactly one registered writeback beat per accepted instruction.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   flush              kill the EX instruction / suppress writeback of in-flight access
//   ex_*               instruction presented by EX (sampled only while idle)
//   lsu_stall          combinational hold request towards EX
//   mem_req/we/addr/wdata/wstrb, mem_ready/rdata   data-memory port
//   wb_valid/data/rd/reg_write                      registered writeback beat
//   lsu_fault          1-cycle pulse: misaligned, illegal funct3 or timeout
module mem_lsu #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        lsu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        lsu_fault
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // The counter only ever has to reach MEM_TIMEOUT-1 before the abort fires.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [0:0]    state;
  logic [CW-1:0] tmo_cnt;
  logic [4:0]    lat_rd;
  logic          lat_reg_write;
  logic [2:0]    lat_funct3;
  logic [1:0]    lat_off;
  logic          flushed;

  logic          is_mem;
  logic          illegal_f3;
  logic          misaligned;
  logic          start_acc;
  logic          tmo_hit;
  logic          suppress;
  logic [3:0]    st_wstrb;
  logic [31:0]   st_wdata;
  logic [31:0]   ld_lane;
  logic [31:0]   ld_value;

  assign is_mem = ex_mem_read | ex_mem_write;

  // Legal loads: LB/LH/LW/LBU/LHU. Legal stores: SB/SH/SW only.
  always_comb begin
    illegal_f3 = 1'b0;
    if (ex_mem_read)
      illegal_f3 = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
    else if (ex_mem_write)
      illegal_f3 = ex_funct3[2] || (ex_funct3[1:0] == 2'b11);
  end

  assign misaligned = ((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
                      ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));

  assign start_acc = (state == IDLE) && ex_valid && is_mem && !illegal_f3 &&
                     !misaligned && !flush;

  // Abort fires on the cycle the count of ready-less BUSY cycles reaches MEM_TIMEOUT.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (state == BUSY) && !mem_ready &&
                   (tmo_cnt == CW'(MEM_TIMEOUT - 1));

  // A flush in the completing cycle kills the beat just like an earlier one.
  assign suppress = flushed || flush;

  assign lsu_stall = start_acc || ((state == BUSY) && !mem_ready && !tmo_hit);

  // Store lanes are replicated so the memory can pick bytes by strobe alone.
  always_comb begin
    st_wstrb = 4'hF;
    st_wdata = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << ex_alu_result[1:0];
        st_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << ex_alu_result[1:0];
        st_wdata = {2{ex_store_data[15:0]}};
      end
      default: begin
        st_wstrb = 4'hF;
        st_wdata = ex_store_data;
      end
    endcase
  end

  assign ld_lane = mem_rdata >> {lat_off, 3'b000};

  always_comb begin
    ld_value = ld_lane;
    case (lat_funct3)
      3'b000:  ld_value = {{24{ld_lane[7]}}, ld_lane[7:0]};
      3'b001:  ld_value = {{16{ld_lane[15]}}, ld_lane[15:0]};
      3'b100:  ld_value = {24'b0, ld_lane[7:0]};
      3'b101:  ld_value = {16'b0, ld_lane[15:0]};
      default: ld_value = ld_lane;
    endcase
  end

  // Beat outputs default to a quiet cycle; wb_data and wb_rd hold between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      flushed       <= 1'b0;
      lat_rd        <= '0;
      lat_reg_write <= 1'b0;
      lat_funct3    <= '0;
      lat_off       <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
      lsu_fault     <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      lsu_fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && !flush) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_data      <= ex_alu_result;
              wb_rd        <= ex_rd;
              wb_reg_write <= ex_reg_write;
            end else if (illegal_f3 || misaligned) begin
              wb_valid  <= 1'b1;
              wb_rd     <= ex_rd;
              lsu_fault <= 1'b1;
            end else begin
              state         <= BUSY;
              mem_req       <= 1'b1;
              mem_we        <= ex_mem_write;
              mem_addr      <= {ex_alu_result[31:2], 2'b00};
              mem_wstrb     <= ex_mem_write ? st_wstrb : 4'b0000;
              mem_wdata     <= ex_mem_write ? st_wdata : 32'b0;
              lat_rd        <= ex_rd;
              lat_reg_write <= ex_reg_write;
              lat_funct3    <= ex_funct3;
              lat_off       <= ex_alu_result[1:0];
              flushed       <= 1'b0;
              tmo_cnt       <= '0;
            end
          end
        end
        default: begin
          if (flush)
            flushed <= 1'b1;
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            tmo_cnt <= '0;
            flushed <= 1'b0;
            if (!suppress) begin
              wb_valid <= 1'b1;
              wb_rd    <= lat_rd;
              if (!mem_we) begin
                wb_data      <= ld_value;
                wb_reg_write <= lat_reg_write;
              end
            end
          end else if (tmo_hit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            tmo_cnt <= '0;
            flushed <= 1'b0;
            if (!suppress) begin
              wb_valid  <= 1'b1;
              wb_rd     <= lat_rd;
              lsu_fault <= 1'b1;
            end
          end else if (MEM_TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench for mem_lsu with a short memory timeout.
//
// Each instruction is pushed through applyStimulus, which acts as both the EX
// stage and the data memory. Expected addresses, strobes, store data and load
// results come from modelAccess, which works from byte lanes and plain
// arithmetic. All comparisons go through checkOutput.
module tb_mem_lsu;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        lsu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        lsu_fault;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .lsu_stall(lsu_stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .lsu_fault(lsu_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // What a correct LSU should do with one access, reasoned byte by byte.
  task automatic modelAccess(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, output logic fault,
                             output logic [31:0] word_addr, output logic [3:0] strb,
                             output logic [31:0] wdata, output logic [31:0] ld_val);
    int size;
    int off;
    logic legal;
    logic [31:0] mask;
    logic [31:0] lane;
    size = 1 << f3[1:0];
    off  = int'(addr % 4);
    if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    legal = (f3 <= 3'd2);
    fault = !legal || ((size <= 4) && ((addr % size) != 0));
    word_addr = addr - 32'(off);
    strb  = 4'b0000;
    wdata = 32'b0;
    if (st && size <= 4) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + size) strb[i] = 1'b1;
        wdata[8*i +: 8] = sdata[8*(i % size) +: 8];
      end
    end
    lane = rdata >> (8 * off);
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      lane = lane & mask;
      if (!f3[2] && lane[8*size-1]) lane = lane | ~mask;
    end
    ld_val = lane;
  endtask

  // Presents one instruction, plays memory, and checks every cycle until the
  // beat plus one quiet cycle afterwards.
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [4:0] rd, input logic rw,
                               input logic [31:0] rdata, input int waits,
                               input logic fl_idle, input logic fl_busy);
    logic fault;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0] exp_strb;
    logic is_mem, completes, hold_check;
    logic [31:0] hold_val;
    int n;
    modelAccess(ld, st, f3, addr, sdata, rdata, fault, exp_addr, exp_strb, exp_wdata, exp_ld);
    is_mem = ld | st;
    hold_check = 1'b0;
    hold_val = 32'b0;
    ex_valid = 1'b1; ex_mem_read = ld; ex_mem_write = st; ex_funct3 = f3;
    ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd; ex_reg_write = rw;
    flush = fl_idle; mem_ready = 1'b0;
    #1;
    checkOutput("accept_stall", 32'(lsu_stall), 32'(is_mem && !fault && !fl_idle));
    @(posedge clk); #1;
    flush = 1'b0;
    if (fl_idle) begin
      ex_valid = 1'b0;
      checkOutput("killed_wb_valid", 32'(wb_valid), 32'd0);
      checkOutput("killed_req", 32'(mem_req), 32'd0);
    end else if (!is_mem) begin
      ex_valid = 1'b0;
      checkOutput("pass_wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("pass_wb_data", wb_data, addr);
      checkOutput("pass_wb_rd", 32'(wb_rd), 32'(rd));
      checkOutput("pass_wb_rw", 32'(wb_reg_write), 32'(rw));
      checkOutput("pass_req", 32'(mem_req), 32'd0);
      checkOutput("pass_fault", 32'(lsu_fault), 32'd0);
      hold_check = 1'b1; hold_val = addr;
    end else if (fault) begin
      ex_valid = 1'b0;
      checkOutput("fault_wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("fault_wb_rw", 32'(wb_reg_write), 32'd0);
      checkOutput("fault_pulse", 32'(lsu_fault), 32'd1);
      checkOutput("fault_req", 32'(mem_req), 32'd0);
    end else begin
      checkOutput("req_start", 32'(mem_req), 32'd1);
      checkOutput("req_we", 32'(mem_we), 32'(st));
      checkOutput("req_addr", mem_addr, exp_addr);
      checkOutput("req_wstrb", 32'(mem_wstrb), 32'(exp_strb));
      if (st) checkOutput("req_wdata", mem_wdata, exp_wdata);
      completes = (waits < TMO);
      n = completes ? waits : TMO;
      for (int i = 0; i < n; i++) begin
        flush = fl_busy && (i == 0);
        #1;
        checkOutput("busy_req", 32'(mem_req), 32'd1);
        checkOutput("busy_addr", mem_addr, exp_addr);
        checkOutput("busy_stall", 32'(lsu_stall), 32'(completes || (i != TMO - 1)));
        @(posedge clk); #1;
        flush = 1'b0;
      end
      if (completes) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
        flush = fl_busy && (n == 0);
        #1;
        checkOutput("ready_stall", 32'(lsu_stall), 32'd0);
        checkOutput("ready_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        mem_ready = 1'b0; flush = 1'b0; mem_rdata = $urandom; ex_valid = 1'b0;
        checkOutput("done_req", 32'(mem_req), 32'd0);
        checkOutput("done_wb_valid", 32'(wb_valid), 32'(!fl_busy));
        checkOutput("done_fault", 32'(lsu_fault), 32'd0);
        if (!fl_busy) begin
          checkOutput("done_wb_rw", 32'(wb_reg_write), 32'(ld && rw));
          if (ld) begin
            checkOutput("load_data", wb_data, exp_ld);
            checkOutput("load_rd", 32'(wb_rd), 32'(rd));
            hold_check = 1'b1; hold_val = exp_ld;
          end
        end
      end else begin
        ex_valid = 1'b0;
        checkOutput("tmo_req", 32'(mem_req), 32'd0);
        checkOutput("tmo_wb_valid", 32'(wb_valid), 32'(!fl_busy));
        checkOutput("tmo_fault", 32'(lsu_fault), 32'(!fl_busy));
        checkOutput("tmo_wb_rw", 32'(wb_reg_write), 32'd0);
      end
    end
    // Quiet cycle: a stray mem_ready must be ignored and the beat must not repeat.
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checkOutput("quiet_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("quiet_fault", 32'(lsu_fault), 32'd0);
    checkOutput("quiet_req", 32'(mem_req), 32'd0);
    if (hold_check) checkOutput("quiet_wb_hold", wb_data, hold_val);
  endtask

  initial begin
    logic ld, st, fi, fb, rw;
    logic [2:0] f3;
    logic [31:0] addr;
    int kind;
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0; ex_rd = '0;
    ex_reg_write = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_wstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_fault", 32'(lsu_fault), 32'd0);
    checkOutput("rst_stall", 32'(lsu_stall), 32'd0);
    rst = 1'b0;

    // Directed cases from the test plan.
    applyStimulus(0, 0, 3'd0, 32'h1234_5678, 32'h0, 5'd5, 1, 32'h0, 0, 0, 0);
    applyStimulus(1, 0, 3'd0, 32'h0000_1003, 32'h0, 5'd7, 1, 32'h80AA_BBCC, 0, 0, 0);
    applyStimulus(1, 0, 3'd4, 32'h0000_1003, 32'h0, 5'd7, 1, 32'h80AA_BBCC, 0, 0, 0);
    applyStimulus(0, 1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF, 5'd3, 1, 32'h0, 3, 0, 0);
    applyStimulus(1, 0, 3'd2, 32'h0000_3001, 32'h0, 5'd9, 1, 32'h0, 0, 0, 0);
    applyStimulus(1, 0, 3'd2, 32'h0000_4000, 32'h0, 5'd9, 1, 32'h0, 10, 0, 0);
    applyStimulus(1, 0, 3'd2, 32'h0000_5000, 32'h0, 5'd4, 1, 32'h1111_2222, 2, 0, 1);
    applyStimulus(1, 0, 3'd1, 32'h0000_6002, 32'h0, 5'd4, 1, 32'h9234_5678, 1, 0, 0);
    applyStimulus(0, 1, 3'd0, 32'h0000_7001, 32'h0000_00A5, 5'd1, 0, 32'h0, 0, 1, 0);

    // Reset while an access is outstanding.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'd2;
    ex_alu_result = 32'h0000_8000; ex_rd = 5'd12; ex_reg_write = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstbusy_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstbusy_req", 32'(mem_req), 32'd0);
    checkOutput("rstbusy_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rstbusy_wb_data", wb_data, 32'd0);
    checkOutput("rstbusy_wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("rstbusy_wb_rw", 32'(wb_reg_write), 32'd0);
    checkOutput("rstbusy_stall", 32'(lsu_stall), 32'd0);

    // Randomized mix of pass-through, loads and stores.
    for (int k = 0; k < 80; k++) begin
      kind = int'($urandom_range(0, 2));
      ld = (kind == 1);
      st = (kind == 2);
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      rw = 1'($urandom_range(0, 1));
      fi = ($urandom_range(0, 9) == 0);
      fb = ($urandom_range(0, 5) == 0);
      applyStimulus(ld, st, f3, addr, $urandom, 5'($urandom_range(0, 31)), rw,
                    $urandom, int'($urandom_range(0, 6)), fi, fb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit directly downstream of the execute-stage ALU.
- Consumes the ALU result as an effective address, or as a pass-through value for non-memory ops.
- Drives a single-outstanding request/ready data-memory port: byte/half/word alignment, write strobes, load sign/zero extension.
- Delivers one registered writeback beat per instruction; stalls upstream while a memory access is in flight.

Parameters:
- MEM_TIMEOUT, 255, cycles mem_req may wait for mem_ready before abort with fault; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  kill the instruction at the EX input and suppress writeback of any in-flight access
- ex_valid  in  1  EX presents a valid instruction
- ex_alu_result  in  32  ALU result: effective address for loads/stores, writeback value otherwise
- ex_store_data  in  32  rs2 value for stores
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store (mem_read and mem_write are never both 1)
- ex_funct3  in  3  access size/sign
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- lsu_stall  out  1  hold EX (combinational)
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = store
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables (0 for loads)
- mem_ready  in  1  request accepted/completed this cycle
- mem_rdata  in  32  read word, valid when mem_ready and !mem_we
- wb_valid  out  1  writeback beat valid (1 cycle)
- wb_data  out  32  writeback value
- wb_rd  out  5  destination register
- wb_reg_write  out  1  commit rd
- lsu_fault  out  1  1-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset: state IDLE. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_*, lsu_fault; timeout counter cleared. Reset in BUSY drops mem_req the following cycle with no writeback.
- FSM states IDLE and BUSY. EX inputs are sampled only in IDLE.
- IDLE, ex_valid, no mem op, !flush:
  - Next cycle: wb_valid=1, wb_data=ex_alu_result, wb_rd/wb_reg_write passed through.
  - Latency 1; lsu_stall=0.
- IDLE, mem op, fault:
  - Fault cases: illegal funct3 (load 011/110/111; store anything other than 000/001/010) or misaligned (half with addr[0]=1; word with addr[1:0]≠0).
  - Next cycle: wb_valid=1, wb_reg_write=0, lsu_fault=1. No request issued.
- IDLE, legal aligned mem op, !flush:
  - lsu_stall=1 this cycle.
  - Register mem_addr={addr[31:2],2'b00}, mem_we, mem_wstrb, mem_wdata, rd, funct3 and addr[1:0].
  - State→BUSY; mem_req=1 from the next cycle.
- Store formatting:
  - SB: wstrb=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: wstrb=4'b0011<<addr[1:0], wdata={2{data[15:0]}}.
  - SW: wstrb=4'hF.
- BUSY:
  - mem_req, mem_addr, mem_we, mem_wdata and mem_wstrb are held stable.
  - lsu_stall = !mem_ready.
  - On mem_ready: mem_req=0 and state→IDLE next cycle.
  - Next cycle wb_valid=1. Load: wb_data = extracted lane, sign- (LB/LH) or zero- (LBU/LHU) extended, wb_reg_write as latched. Store: wb_reg_write=0.
  - Minimum load/store latency: 2 cycles from acceptance to wb_valid.
- Timeout: counter increments each BUSY cycle without mem_ready. On reaching MEM_TIMEOUT (if nonzero):
  - mem_req drops, state→IDLE.
  - Next cycle: wb_valid=1, wb_reg_write=0, lsu_fault=1.
  - lsu_stall=0 in that cycle.
- flush:
  - In IDLE: the EX instruction is discarded, no wb_valid, no request.
  - In BUSY: the access runs to mem_ready/timeout, but its writeback beat has wb_valid=0 and lsu_fault=0. A flush-marked flag is set and cleared on completion.
- mem_ready while mem_req=0 is ignored.
- wb_data is held when wb_valid=0; wb_valid never asserts on two consecutive cycles for the same instruction.

Test Plan:
- ALU pass-through: ex_valid, alu_result=0x1234_5678, rd=5 → next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5, no mem_req.
- LB sign extension: addr=0x1003, mem_rdata=0x80AA_BBCC, ready on first req cycle → mem_addr=0x1000, wb_data=0xFFFFFF80, wb_valid 2 cycles after acceptance. Same with LBU → 0x00000080.
- SH at addr=0x2002, store_data=0xDEAD_BEEF, ready after 3 wait cycles → mem_wstrb=4'b1100, mem_wdata=0xBEEFBEEF, lsu_stall=1 until the ready cycle, wb_reg_write=0.
- Misaligned LW at 0x3001 → no mem_req, lsu_fault=1 for one cycle, wb_reg_write=0.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → mem_req high exactly 4 cycles, then lsu_fault=1 and lsu_stall released.
- Flush in BUSY and rst in BUSY: flush → wb_valid stays 0 after ready; rst → mem_req=0 and all wb outputs 0 the next cycle.
